// File: rtl/mem_stage_lsu_if.sv
// Memory bus between the M-stage load/store unit and the data memory.
//   mem_req   : request, held high until mem_ack or timeout
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables (all zero on loads)
//   mem_wdata : store data replicated across the byte lanes
//   mem_rdata : read word returned by memory
//   mem_ack   : single-cycle completion strobe
interface mem_stage_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit. Turns a load/store in the M stage into a single
// bus transaction, stalls the pipeline while the transaction is in flight,
// formats load data and flags misaligned/illegal accesses and bus timeouts.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   MemReadM, MemWriteM   : load / store in M (store wins if both set)
//   Funct3M               : access size and signedness
//   ALUResultM            : byte address
//   WriteDataM            : right-justified store data
//   bus                   : memory bus (master side)
//   ReadDataM             : formatted load result (registered)
//   StallM                : freeze F/D/E/M while an access is outstanding
//   MisalignM             : misaligned address or illegal Funct3M
//   BusErrM               : no ack within TIMEOUT BUSY cycles
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    mem_stage_lsu_if.master       bus,
    output logic [31:0]           ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  BusErrM
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [15:0] wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        access, fault, issue, complete, timeout_hit;

    // Store data replicated so every enabled lane carries the right bytes.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Pick the addressed byte/halfword lane and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0]        sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        sh  = rd >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (f3)
            3'b000:  return 32'(b_s);
            3'b001:  return 32'(h_s);
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        access = MemReadM | MemWriteM;
        fault  = !(Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               || (Funct3M[1:0] == 2'b01 && ALUResultM[0])
               || (Funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
    end

    always_comb begin
        state_n     = state;
        StallM      = 1'b0;
        MisalignM   = 1'b0;
        issue       = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        // Hold the pipeline outputs quiet while reset is applied.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (fault) begin
                            MisalignM = 1'b1;
                        end else begin
                            StallM  = 1'b1;
                            issue   = 1'b1;
                            state_n = BUSY;
                        end
                    end
                end
                BUSY: begin
                    StallM = 1'b1;
                    if (bus.mem_ack) begin
                        complete = 1'b1;
                        state_n  = DONE;
                    end else if (wait_cnt >= CNT_LAST) begin
                        timeout_hit = 1'b1;
                        state_n     = DONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            ReadDataM     <= '0;
            BusErrM       <= 1'b0;
            wait_cnt      <= '0;
            f3_q          <= '0;
            off_q         <= '0;
        end else begin
            state   <= state_n;
            // Only the DONE cycle that follows a timeout sees BusErrM high.
            BusErrM <= timeout_hit;
            if (issue) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= MemWriteM;
                bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
                bus.mem_be    <= MemWriteM ? lane_be(Funct3M, ALUResultM[1:0]) : 4'b0000;
                bus.mem_wdata <= MemWriteM ? lane_wdata(Funct3M, WriteDataM) : 32'd0;
                f3_q          <= Funct3M;
                off_q         <= ALUResultM[1:0];
                wait_cnt      <= '0;
            end else if (state == BUSY) begin
                if (complete || timeout_hit) begin
                    bus.mem_req <= 1'b0;
                end else if (wait_cnt != 16'hFFFF) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                if (complete && !bus.mem_we) begin
                    ReadDataM <= fmt_load(f3_q, off_q, bus.mem_rdata);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with TIMEOUT=4: loads/stores of every
// size, misaligned and illegal accesses, bus timeout, stray acks and
// reset in the middle of an access.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    int n_chk = 0;
    int n_bad = 0;

    // Results gathered by run_access.
    int          r_stall, r_req;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_stable, r_done;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .bus        (bus.master),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_inputs();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    // Starts in IDLE at 1ns after an edge; returns in the DONE cycle.
    task automatic run_access(input string tag, input logic st, input logic rd_too,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdv,
                              input int waits, input logic ack_en);
        logic prev_req;
        MemReadM   = !st | rd_too;
        MemWriteM  = st;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        r_stall = 0; r_req = 0; r_stable = 1'b1; r_done = 1'b0;
        for (int c = 0; c < 40 && !r_done; c++) begin
            #1;
            if (StallM) r_stall++;
            if (bus.mem_req) begin
                if (r_req == 0) begin
                    r_addr = bus.mem_addr; r_be = bus.mem_be;
                    r_wdata = bus.mem_wdata; r_we = bus.mem_we;
                end else if (bus.mem_addr !== r_addr || bus.mem_be !== r_be ||
                             bus.mem_wdata !== r_wdata || bus.mem_we !== r_we) begin
                    r_stable = 1'b0;
                end
                if (ack_en && r_req == waits) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdv;
                end
                r_req++;
            end
            prev_req = bus.mem_req;
            step();
            bus.mem_ack = 1'b0;
            if (prev_req && !bus.mem_req) r_done = 1'b1;
        end
        drop_inputs();
        check({tag, "_done"}, 32'(r_done), 32'd1);
        check({tag, "_stable"}, 32'(r_stable), 32'd1);
    endtask

    task automatic fault_case(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] a);
        logic saw_req;
        MemReadM   = !st;
        MemWriteM  = st;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = 32'h5555_AAAA;
        #1;
        check({tag, "_mis"}, 32'(MisalignM), 32'd1);
        check({tag, "_stall"}, 32'(StallM), 32'd0);
        saw_req = 1'b0;
        repeat (3) begin
            step();
            if (bus.mem_req) saw_req = 1'b1;
        end
        check({tag, "_req"}, 32'(saw_req), 32'd0);
        check({tag, "_rd"}, ReadDataM, exp_rd);
        drop_inputs();
    endtask

    initial begin
        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = '0; WriteDataM = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        exp_rd = '0;
        repeat (3) step();
        check("rst_req",   32'(bus.mem_req), 32'd0);
        check("rst_we",    32'(bus.mem_we), 32'd0);
        check("rst_addr",  bus.mem_addr, 32'd0);
        check("rst_be",    32'(bus.mem_be), 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_rd",    ReadDataM, 32'd0);
        check("rst_berr",  32'(BusErrM), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_mis",   32'(MisalignM), 32'd0);
        reset = 1'b0;
        step();

        // LB from the top byte lane, ack in the first BUSY cycle.
        run_access("lb", 1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1'b1);
        exp_rd = 32'hFFFF_FF80;
        check("lb_addr", r_addr, 32'h100);
        check("lb_be", 32'(r_be), 32'h0);
        check("lb_we", 32'(r_we), 32'd0);
        check("lb_rd", ReadDataM, exp_rd);
        check("lb_stall", 32'(r_stall), 32'd2);
        check("lb_done_stall", 32'(StallM), 32'd0);
        check("lb_berr", 32'(BusErrM), 32'd0);
        step();

        // SH upper half, three wait cycles before the ack.
        run_access("sh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1'b1);
        check("sh_we", 32'(r_we), 32'd1);
        check("sh_addr", r_addr, 32'h200);
        check("sh_be", 32'(r_be), 32'hC);
        check("sh_wdata", r_wdata, 32'hABCD_ABCD);
        check("sh_stall", 32'(r_stall), 32'd5);
        check("sh_rd", ReadDataM, exp_rd);
        step();

        run_access("sb", 1'b1, 1'b0, 3'b000, 32'h201, 32'h0000_00EE, 32'h0, 0, 1'b1);
        check("sb_be", 32'(r_be), 32'h2);
        check("sb_wdata", r_wdata, 32'hEEEE_EEEE);
        step();

        run_access("lh", 1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0, 1'b1);
        exp_rd = 32'hFFFF_8001;
        check("lh_rd", ReadDataM, exp_rd);
        step();

        run_access("lbu", 1'b0, 1'b0, 3'b100, 32'h1, 32'h0, 32'h0000_9A00, 0, 1'b1);
        exp_rd = 32'h0000_009A;
        check("lbu_rd", ReadDataM, exp_rd);
        step();

        // Store and load both requested: the store wins.
        run_access("sw", 1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'h1111_1111, 0, 1'b1);
        check("sw_we", 32'(r_we), 32'd1);
        check("sw_be", 32'(r_be), 32'hF);
        check("sw_wdata", r_wdata, 32'hCAFE_F00D);
        check("sw_rd", ReadDataM, exp_rd);
        step();

        run_access("lw", 1'b0, 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEAD_BEEF, 1, 1'b1);
        exp_rd = 32'hDEAD_BEEF;
        check("lw_rd", ReadDataM, exp_rd);
        check("lw_stall", 32'(r_stall), 32'd3);
        step();

        fault_case("lw_mis", 1'b0, 3'b010, 32'h101);
        fault_case("f3_011", 1'b0, 3'b011, 32'h100);
        fault_case("lh_mis", 1'b0, 3'b001, 32'h103);
        fault_case("sw_mis", 1'b1, 3'b010, 32'h102);

        // No ack: four BUSY cycles, then a single DONE cycle with BusErrM.
        run_access("tmo", 1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 1'b0);
        check("tmo_req", 32'(r_req), 32'd4);
        check("tmo_berr", 32'(BusErrM), 32'd1);
        check("tmo_rd", ReadDataM, exp_rd);
        step();
        check("tmo_berr_clr", 32'(BusErrM), 32'd0);

        // Ack while idle must have no effect.
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
        step(); step();
        bus.mem_ack = 1'b0;
        check("stray_rd", ReadDataM, exp_rd);
        check("stray_req", 32'(bus.mem_req), 32'd0);

        // Reset during the second BUSY cycle of an LHU.
        MemReadM = 1'b1; Funct3M = 3'b101; ALUResultM = 32'h6;
        step(); step();
        check("mid_req_busy", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        drop_inputs();
        #1;
        check("mid_req", 32'(bus.mem_req), 32'd0);
        check("mid_stall", 32'(StallM), 32'd0);
        check("mid_rd", ReadDataM, 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        reset = 1'b0;
        step();
        bus.mem_ack = 1'b0;
        exp_rd = 32'd0;
        check("mid_ack_rd", ReadDataM, exp_rd);
        check("mid_ack_req", 32'(bus.mem_req), 32'd0);

        run_access("lhu", 1'b0, 1'b0, 3'b101, 32'h6, 32'h0, 32'hF00D_0000, 0, 1'b1);
        check("lhu_addr", r_addr, 32'h4);
        check("lhu_rd", ReadDataM, 32'h0000_F00D);
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
